// File: rtl/logic_op_pkg.sv
// Shared definitions for the byte-serial front end of the AND/OR logic unit.
package logic_op_pkg;

  // Default operand / byte width of the logic unit.
  localparam int LOGIC_W = 8;

  // Bit of the opcode byte that selects the operation (1 = AND, 0 = OR).
  localparam int OP_SEL_BIT = 0;

  // Frame sequencer states: three input bytes, one execute cycle, one output hold.
  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_OUT  = 3'd4
  } state_t;

endpackage : logic_op_pkg

// File: rtl/logic_op_loader.sv
// Byte-serial front end for the bitwise AND/OR logic unit.
// Assembles (opcode, A, B) frames from a valid/ready byte stream, holds the
// operands and select bit on the logic-unit drive ports, samples the unit's
// combinational result in a single execute cycle and returns it on a
// registered valid/ready output stream together with an illegal-opcode flag.
module logic_op_loader
  import logic_op_pkg::*;
#(
  parameter int W = LOGIC_W
) (
  input  logic         clk,
  input  logic         rst,
  // Byte input stream
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  // Drive ports of the logic unit and its combinational result
  output logic         op_x,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  input  logic [W-1:0] op_result,
  // Result stream
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err,
  output logic [7:0]   frame_cnt
);

  state_t       state_q, state_d;
  logic         op_x_q, op_x_d;
  logic [W-1:0] op_a_q, op_a_d;
  logic [W-1:0] op_b_q, op_b_d;
  logic         err_q, err_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_err_q, out_err_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;

  logic         in_state;
  logic         accept;
  logic [W-1:0] opcode_extra;

  // Only the select bit may be set in a legal opcode; any other bit marks the frame illegal.
  assign opcode_extra = in_data & ~(W'(1) << OP_SEL_BIT);

  // The block takes bytes only while assembling a frame and never while reset is held.
  assign in_state = (state_q == S_OP) || (state_q == S_A) || (state_q == S_B);
  assign in_ready = in_state && !rst;
  assign accept   = in_valid && in_ready;

  // State register; reset is synchronous so it is sampled like any other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (rst) begin
      state_q <= S_OP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and register-load decisions for the frame sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch instead of combinational logic.
    state_d     = state_q;
    op_x_d      = op_x_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      S_OP: begin
        if (accept) begin
          op_x_d  = in_data[OP_SEL_BIT];
          err_d   = |opcode_extra;
          state_d = S_A;
        end
      end
      S_A: begin
        if (accept) begin
          op_a_d  = in_data;
          state_d = S_B;
        end
      end
      S_B: begin
        if (accept) begin
          op_b_d  = in_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Operands have been stable since the B accept, so the unit's result is settled here.
        out_data_d = err_q ? '0 : op_result;
        out_err_d  = err_q;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = S_OP;
        end
      end
      default: begin
        state_d = S_OP;
      end
    endcase
  end

  // Operand bank, error flag, result register and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_x_q      <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      op_x_q      <= op_x_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Output valid is a decode of the registered state, so it is glitch-free and
  // drops only after a handshake or a reset.
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign frame_cnt = frame_cnt_q;

  assign op_x = op_x_q;
  assign op_a = op_a_q;
  assign op_b = op_b_q;

endmodule : logic_op_loader
